// File: rtl/fetch_decode_buffer.sv
// fetch_decode_buffer: DEPTH-entry {pc, instruction} FIFO between fetch and decode with synchronous flush.
// Define FD_BUFFER_OCCUPANCY_EN to expose the registered entry count on the occupancy port.
module fetch_decode_buffer #(
   parameter int DATA_WIDTH = 32,
   parameter int PC_WIDTH   = 32,
   parameter int DEPTH      = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_instruction,
   input  logic [PC_WIDTH-1:0]   in_pc,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_instruction,
   output logic [PC_WIDTH-1:0]   out_pc
`ifdef FD_BUFFER_OCCUPANCY_EN
   ,
   output logic [$clog2(DEPTH):0] occupancy
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = DATA_WIDTH + PC_WIDTH;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
      $error("fetch_decode_buffer: DEPTH must be a power of two >= 2");
   end

   logic [EW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          push, pop;

   assign in_ready  = (count != FULL) & ~flush;
   assign out_valid = (count != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign {out_pc, out_instruction} = mem[rd_ptr];

`ifdef FD_BUFFER_OCCUPANCY_EN
   assign occupancy = count;
`endif

   // storage is reset too so out_* read as zero straight out of reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= {in_pc, in_instruction};
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end

`ifndef SYNTHESIS
   a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && count == FULL));
   a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) !(pop && count == '0));
   a_count_bound:  assert property (@(posedge clk) disable iff (!rst_n) count <= FULL);
`endif
endmodule

// File: tb/tb_fetch_decode_buffer.sv
// tb_fetch_decode_buffer: directed checks of a DEPTH=2 and a DEPTH=4 fetch_decode_buffer.
module tb_fetch_decode_buffer;
   localparam logic [31:0] XK = 32'hA500_0013;

   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;

   logic fl2 = 0, iv2 = 0, or2 = 0, ir2, ov2;
   logic [31:0] ins2 = 0, pc2 = 0, oins2, opc2;
   logic fl4 = 0, iv4 = 0, or4 = 0, ir4, ov4;
   logic [31:0] ins4 = 0, pc4 = 0, oins4, opc4;
`ifdef FD_BUFFER_OCCUPANCY_EN
   logic [1:0] occ2;
   logic [2:0] occ4;
`endif

   fetch_decode_buffer #(.DATA_WIDTH(32), .PC_WIDTH(32), .DEPTH(2)) d2 (
      .clk(clk), .rst_n(rst_n), .flush(fl2), .in_valid(iv2), .in_ready(ir2),
      .in_instruction(ins2), .in_pc(pc2), .out_valid(ov2), .out_ready(or2),
      .out_instruction(oins2), .out_pc(opc2)
`ifdef FD_BUFFER_OCCUPANCY_EN
      , .occupancy(occ2)
`endif
   );

   fetch_decode_buffer #(.DATA_WIDTH(32), .PC_WIDTH(32), .DEPTH(4)) d4 (
      .clk(clk), .rst_n(rst_n), .flush(fl4), .in_valid(iv4), .in_ready(ir4),
      .in_instruction(ins4), .in_pc(pc4), .out_valid(ov4), .out_ready(or4),
      .out_instruction(oins4), .out_pc(opc4)
`ifdef FD_BUFFER_OCCUPANCY_EN
      , .occupancy(occ4)
`endif
   );

   int total = 0, passed = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   typedef struct {
      logic        fl, iv;
      logic [31:0] pc;
      logic        orr, ov, ir;
      logic [31:0] epc;
      int          occ;
   } vec_t;
   vec_t tbl[22];

   initial begin
      // rows: flush, in_valid, in_pc, out_ready | out_valid, in_ready, out_pc, occupancy (before the edge)
      tbl[0]  = '{0, 1, 32'h00, 0, 0, 1, 32'h00, 0};
      tbl[1]  = '{0, 1, 32'h04, 0, 1, 1, 32'h00, 1};
      tbl[2]  = '{0, 1, 32'h08, 0, 1, 1, 32'h00, 2};
      tbl[3]  = '{0, 1, 32'h0C, 0, 1, 1, 32'h00, 3};
      tbl[4]  = '{0, 1, 32'h10, 0, 1, 0, 32'h00, 4};
      tbl[5]  = '{0, 0, 32'h00, 1, 1, 0, 32'h00, 4};
      tbl[6]  = '{0, 0, 32'h00, 1, 1, 1, 32'h04, 3};
      tbl[7]  = '{0, 0, 32'h00, 1, 1, 1, 32'h08, 2};
      tbl[8]  = '{0, 0, 32'h00, 1, 1, 1, 32'h0C, 1};
      tbl[9]  = '{0, 0, 32'h00, 0, 0, 1, 32'h00, 0};
      tbl[10] = '{0, 1, 32'h20, 0, 0, 1, 32'h00, 0};
      tbl[11] = '{0, 1, 32'h24, 0, 1, 1, 32'h20, 1};
      tbl[12] = '{0, 1, 32'h28, 0, 1, 1, 32'h20, 2};
      tbl[13] = '{1, 1, 32'h2C, 0, 1, 0, 32'h20, 3};
      tbl[14] = '{0, 1, 32'h30, 0, 0, 1, 32'h00, 0};
      tbl[15] = '{0, 0, 32'h00, 1, 1, 1, 32'h30, 1};
      tbl[16] = '{0, 0, 32'h00, 0, 0, 1, 32'h00, 0};
      tbl[17] = '{0, 1, 32'h40, 0, 0, 1, 32'h00, 0};
      tbl[18] = '{0, 1, 32'h44, 1, 1, 1, 32'h40, 1};
      tbl[19] = '{1, 0, 32'h00, 1, 1, 0, 32'h44, 1};
      tbl[20] = '{1, 0, 32'h00, 0, 0, 0, 32'h00, 0};
      tbl[21] = '{0, 0, 32'h00, 0, 0, 1, 32'h00, 0};

      // reset held, DEPTH=2
      #2;
      chk("rst_ov", ov2, 0);
      chk("rst_ir", ir2, 1);
      chk("rst_pc", opc2, 0);
      chk("rst_ins", oins2, 0);
`ifdef FD_BUFFER_OCCUPANCY_EN
      chk("rst_occ", occ2, 0);
`endif
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("idle_ov", ov2, 0);
      chk("idle_ir", ir2, 1);

      // single push, DEPTH=2
      @(negedge clk) begin iv2 = 1; pc2 = 32'h100; ins2 = 32'h13; or2 = 1; end
      #1 chk("single_pre_ov", ov2, 0);
      @(negedge clk) iv2 = 0;
      #1;
      chk("single_ov", ov2, 1);
      chk("single_pc", opc2, 32'h100);
      chk("single_ins", oins2, 32'h13);
      @(negedge clk) #1 chk("single_drain", ov2, 0);

      // streaming across pointer wrap, DEPTH=2
      @(negedge clk) begin iv2 = 1; pc2 = 0; ins2 = XK; or2 = 1; end
      for (int k = 1; k < 10; k++) begin
         @(negedge clk) begin pc2 = 32'(4 * k); ins2 = pc2 ^ XK; end
         #1;
         chk($sformatf("stream_ov%0d", k), ov2, 1);
         chk($sformatf("stream_ir%0d", k), ir2, 1);
         chk($sformatf("stream_pc%0d", k), opc2, 32'(4 * (k - 1)));
         chk($sformatf("stream_ins%0d", k), oins2, 32'(4 * (k - 1)) ^ XK);
      end
      @(negedge clk) iv2 = 0;
      #1 chk("stream_last_pc", opc2, 32'h24);
      @(negedge clk) #1 chk("stream_empty", ov2, 0);
      or2 = 0;

      // fill, drain, flush, DEPTH=4
      for (int i = 0; i < 22; i++) begin
         @(negedge clk) begin
            fl4 = tbl[i].fl; iv4 = tbl[i].iv; pc4 = tbl[i].pc;
            ins4 = tbl[i].pc ^ XK; or4 = tbl[i].orr;
         end
         #1;
         chk($sformatf("v%0d_ov", i), ov4, tbl[i].ov);
         chk($sformatf("v%0d_ir", i), ir4, tbl[i].ir);
         if (tbl[i].ov) begin
            chk($sformatf("v%0d_pc", i), opc4, tbl[i].epc);
            chk($sformatf("v%0d_ins", i), oins4, tbl[i].epc ^ XK);
         end
`ifdef FD_BUFFER_OCCUPANCY_EN
         chk($sformatf("v%0d_occ", i), occ4, 64'(tbl[i].occ));
`endif
      end

      // asynchronous reset mid-cycle with two entries queued, DEPTH=4
      @(negedge clk) begin fl4 = 0; iv4 = 1; pc4 = 32'h50; ins4 = 32'h50 ^ XK; or4 = 0; end
      @(negedge clk) begin pc4 = 32'h54; ins4 = 32'h54 ^ XK; end
      @(negedge clk) iv4 = 0;
      #1;
      chk("pre_arst_ov", ov4, 1);
      chk("pre_arst_pc", opc4, 32'h50);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_ov", ov4, 0);
      chk("arst_ir", ir4, 1);
      chk("arst_pc", opc4, 0);
`ifdef FD_BUFFER_OCCUPANCY_EN
      chk("arst_occ", occ4, 0);
`endif
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk) #1;
      chk("post_arst_ov", ov4, 0);
      chk("post_arst_ir", ir4, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
